// File: rtl/seg_scan_receiver.sv
// Receiver for a multiplexed 4-digit 7-segment bus: reassembles scanned digits into BCD plus binary score.
// Build option: SEG_BLANK_ZERO_EN makes the all-off pattern decode as digit 0.
//
// state | meaning
// IDLE  | waiting for a ones-digit capture to start a frame
// GOT1  | ones captured, expecting tens
// GOT2  | tens captured, expecting hundreds
// GOT3  | hundreds captured, expecting thousands
// DONE  | frame published this cycle, returns to IDLE
module seg_scan_receiver #(
   parameter int SETTLE_CYCLES  = 4,
   parameter int TIMEOUT_CYCLES = 2000000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [3:0]  an,
   input  logic [7:0]  segCode,
   output logic [3:0]  digit_ones,
   output logic [3:0]  digit_tens,
   output logic [3:0]  digit_hund,
   output logic [3:0]  digit_thou,
   output logic [13:0] score,
   output logic        frame_valid,
   output logic        decode_err,
   output logic        anode_err,
   output logic        locked
);

   localparam int SW = $clog2(SETTLE_CYCLES + 1);
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [SW-1:0] SETTLE_CAP = SW'(SETTLE_CYCLES - 2);
   localparam logic [SW-1:0] SETTLE_MAX = SW'(SETTLE_CYCLES - 1);
   localparam logic [TW-1:0] TO_MAX     = TW'(TIMEOUT_CYCLES);

   localparam logic [2:0] IDLE = 3'd0;
   localparam logic [2:0] GOT1 = 3'd1;
   localparam logic [2:0] GOT2 = 3'd2;
   localparam logic [2:0] GOT3 = 3'd3;
   localparam logic [2:0] DONE = 3'd4;

   logic [3:0]    an_s1, an_s2, an_prev;
   logic [7:0]    seg_s1, seg_s2, seg_prev;
   logic [SW-1:0] stab_cnt;
   logic [TW-1:0] to_cnt;
   logic [2:0]    state;
   logic [3:0]    d_ones, d_tens, d_hund;
   logic          same, cap;
   logic          dec_ok, an_legal;
   logic [3:0]    dec_val;
   logic [1:0]    an_pos;
   logic          in_frame;
   logic [13:0]   score_new;

   assign same     = ({an_s2, seg_s2} == {an_prev, seg_prev});
   assign cap      = same && (stab_cnt == SETTLE_CAP);
   assign in_frame = (state == GOT1) || (state == GOT2) || (state == GOT3);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         an_s1    <= '0;
         an_s2    <= '0;
         an_prev  <= '0;
         seg_s1   <= '0;
         seg_s2   <= '0;
         seg_prev <= '0;
         stab_cnt <= '0;
         to_cnt   <= '0;
      end else begin
         an_s1    <= an;
         an_s2    <= an_s1;
         seg_s1   <= segCode;
         seg_s2   <= seg_s1;
         an_prev  <= an_s2;
         seg_prev <= seg_s2;
         if (!same)
            stab_cnt <= '0;
         else if (stab_cnt != SETTLE_MAX)
            stab_cnt <= stab_cnt + SW'(1);
         if (cap)
            to_cnt <= '0;
         else if (to_cnt != TO_MAX)
            to_cnt <= to_cnt + TW'(1);
      end
   end

   always_comb begin
      dec_ok  = 1'b1;
      dec_val = 4'd0;
      case (seg_s2[6:0])
         7'b1000000: dec_val = 4'd0;
         7'b1111001: dec_val = 4'd1;
         7'b0100100: dec_val = 4'd2;
         7'b0110000: dec_val = 4'd3;
         7'b0011001: dec_val = 4'd4;
         7'b0010010: dec_val = 4'd5;
         7'b0000010: dec_val = 4'd6;
         7'b1111000: dec_val = 4'd7;
         7'b0000000: dec_val = 4'd8;
         7'b0010000: dec_val = 4'd9;
`ifdef SEG_BLANK_ZERO_EN
         7'b1111111: dec_val = 4'd0;
`endif
         default:    dec_ok  = 1'b0;
      endcase
   end

   always_comb begin
      an_legal = 1'b1;
      an_pos   = 2'd0;
      case (an_s2)
         4'b1110: an_pos = 2'd0;
         4'b1101: an_pos = 2'd1;
         4'b1011: an_pos = 2'd2;
         4'b0111: an_pos = 2'd3;
         default: an_legal = 1'b0;
      endcase
   end

   assign score_new = {10'd0, dec_val} * 14'd1000 + {10'd0, d_hund} * 14'd100
                    + {10'd0, d_tens} * 14'd10 + {10'd0, d_ones};

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state       <= IDLE;
         d_ones      <= '0;
         d_tens      <= '0;
         d_hund      <= '0;
         digit_ones  <= '0;
         digit_tens  <= '0;
         digit_hund  <= '0;
         digit_thou  <= '0;
         score       <= '0;
         frame_valid <= 1'b0;
         decode_err  <= 1'b0;
         anode_err   <= 1'b0;
         locked      <= 1'b0;
      end else begin
         frame_valid <= 1'b0;
         decode_err  <= 1'b0;
         anode_err   <= 1'b0;
         if (state == DONE) begin
            state <= IDLE;
         end else if (cap) begin
            if (!an_legal) begin
               anode_err <= 1'b1;
               locked    <= 1'b0;
               state     <= IDLE;
            end else if (state == IDLE && an_pos != 2'd0) begin
               state <= IDLE;
            end else if (!dec_ok) begin
               decode_err <= 1'b1;
               locked     <= 1'b0;
               state      <= IDLE;
            end else if (state == IDLE) begin
               d_ones <= dec_val;
               state  <= GOT1;
            end else if ({1'b0, an_pos} == state) begin
               // in-order digit: GOTn expects anode position n
               case (an_pos)
                  2'd1:    d_tens <= dec_val;
                  2'd2:    d_hund <= dec_val;
                  default: d_hund <= d_hund;
               endcase
               if (state == GOT3) begin
                  digit_ones  <= d_ones;
                  digit_tens  <= d_tens;
                  digit_hund  <= d_hund;
                  digit_thou  <= dec_val;
                  score       <= score_new;
                  frame_valid <= 1'b1;
                  locked      <= 1'b1;
                  state       <= DONE;
               end else begin
                  state <= state + 3'd1;
               end
            end else begin
               anode_err <= 1'b1;
               locked    <= 1'b0;
               if (an_pos == 2'd0) begin
                  d_ones <= dec_val;
                  state  <= GOT1;
               end else begin
                  state <= IDLE;
               end
            end
         end else if (in_frame && to_cnt == TO_MAX) begin
            state  <= IDLE;
            locked <= 1'b0;
         end
      end
   end

endmodule
